// File: rtl/mcpu_dcresp_pkg.sv
// mcpu_dcresp_pkg: shared types and constants for the data-side memory responder.
//   - dcresp_state_e : responder FSM states (IDLE / WAIT / RESP)
//   - WORD_W, MASK_W, PADDR_W : data word, byte-mask and word-address widths
//   - CNT_W          : wait-counter width (covers 15 fixed + 3 random wait states)
//   - LFSR_SEED, LFSR_TAPS : 16-bit Fibonacci LFSR seed and tap mask (16,14,13,11)
package mcpu_dcresp_pkg;

  localparam int WORD_W  = 32;
  localparam int MASK_W  = 4;
  localparam int PADDR_W = 30;
  localparam int CNT_W   = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bit i set means stage i+1 feeds back: stages 16, 14, 13, 11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dcresp_state_e;

endpackage

// File: rtl/mcpu_lfsr16.sv
// mcpu_lfsr16: free-running 16-bit Fibonacci LFSR, stepping every clock.
//   clk_i   in  clock (rising edge)
//   rst_i   in  synchronous active-high reset, loads LFSR_SEED
//   lfsr_o  out current LFSR state
module mcpu_lfsr16
  import mcpu_dcresp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic        fb_s;

  // Feedback is the XOR of the tapped stages; new bit enters at the LSB.
  assign fb_s = ^(lfsr_q & LFSR_TAPS);

  // Shift register state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], fb_s};
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mcpu_dcache_resp.sv
// mcpu_dcache_resp: data-side memory responder behind the mem2dc_* bus. Accepts a
// word-addressed request, performs a byte-masked write or full-word read on an
// internal 2^ADDR_BITS x 32 array, and answers with a one-cycle done strobe.
//   clkrst_core_clk  in     core clock
//   clkrst_core_rst  in     synchronous active-high reset
//   mem2dc_paddr     in     word address (bits above ADDR_BITS alias)
//   mem2dc_write     in     byte-lane write mask, 0 = read
//   mem2dc_valid     in     request valid, held until done
//   mem2dc_done      out    one-cycle response strobe
//   mem2dc_data      inout  write data in / read data out / Z otherwise
// Build option: MCPU_DCRESP_RANDWAIT_EN adds 0..3 pseudo-random wait states per
// access from a 16-bit LFSR.
module mcpu_dcache_resp
  import mcpu_dcresp_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 1
)(
  input  logic               clkrst_core_clk,
  input  logic               clkrst_core_rst,
  input  logic [PADDR_W-1:0] mem2dc_paddr,
  input  logic [MASK_W-1:0]  mem2dc_write,
  input  logic               mem2dc_valid,
  output logic               mem2dc_done,
  inout  wire  [WORD_W-1:0]  mem2dc_data
);

  dcresp_state_e        state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [MASK_W-1:0]    mask_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [WORD_W-1:0]    rdata_q;
  logic [WORD_W-1:0]    mem_q [2**ADDR_BITS];

  logic [CNT_W-1:0]     wait_load_s;
  logic                 resp_live_s;
  logic                 bus_oe_s;
  logic                 unused_paddr_s;

  // Upper address bits are intentionally dropped so addresses alias.
  assign unused_paddr_s = ^mem2dc_paddr;

`ifdef MCPU_DCRESP_RANDWAIT_EN
  logic [15:0] lfsr_s;
  logic        unused_lfsr_s;

  mcpu_lfsr16 u_lfsr (
    .clk_i  (clkrst_core_clk),
    .rst_i  (clkrst_core_rst),
    .lfsr_o (lfsr_s)
  );

  assign unused_lfsr_s = ^lfsr_s[15:2];
  assign wait_load_s   = CNT_W'(WAIT_CYCLES) + {3'b000, lfsr_s[1:0]};
`else
  assign wait_load_s   = CNT_W'(WAIT_CYCLES);
`endif

  // Response is only live while the initiator still holds valid; dropping it aborts.
  assign resp_live_s = (state_q == RESP) && mem2dc_valid;
  assign mem2dc_done = resp_live_s;
  assign bus_oe_s    = resp_live_s && (mask_q == 4'b0000);
  assign mem2dc_data = bus_oe_s ? rdata_q : {WORD_W{1'bz}};

  // Request FSM: accept, count wait states, present response.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem2dc_valid) begin
            addr_q <= mem2dc_paddr[ADDR_BITS-1:0];
            mask_q <= mem2dc_write;
            if (mem2dc_write != 4'b0000) begin
              wdata_q <= mem2dc_data;
            end
            cnt_q <= wait_load_s;
            if (wait_load_s == CNT_W'(0)) begin
              // No wait states: the array read happens on the accept cycle.
              rdata_q <= mem_q[mem2dc_paddr[ADDR_BITS-1:0]];
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!mem2dc_valid) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              rdata_q <= mem_q[addr_q];
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Byte-lane write commit in the live response cycle; reset suppresses it.
  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst && resp_live_s) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (mask_q[i]) begin
          mem_q[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mcpu_dcache_resp.sv
module tb_mcpu_dcache_resp;
  import mcpu_dcresp_pkg::*;

  localparam int AB = 10;
  localparam int WC = 1;
`ifdef MCPU_DCRESP_RANDWAIT_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] paddr = 30'd0;
  logic [3:0]  wmask = 4'd0;
  logic        valid = 1'b0;
  logic        done;
  logic [31:0] drv = 32'd0;
  logic        oe = 1'b0;
  wire  [31:0] bus;

  assign bus = oe ? drv : 32'bz;

  always #5 clk = ~clk;

  mcpu_dcache_resp #(.ADDR_BITS(AB), .WAIT_CYCLES(WC)) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .mem2dc_paddr    (paddr),
    .mem2dc_write    (wmask),
    .mem2dc_valid    (valid),
    .mem2dc_done     (done),
    .mem2dc_data     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks latency, data, drive.
  exp_t m_e;
  int   m_lat;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no response (cycle %0d)", cyc);
      end else begin
        m_e   = sb.pop_front();
        m_lat = cyc - m_e.acc;
        if (m_lat < WC + 1 || m_lat > WC + 1 + EXTRA) begin
          errors++;
          $display("FAIL latency: got %0d, expected %0d..%0d", m_lat, WC + 1, WC + 1 + EXTRA);
        end
        if (m_e.rd) chk("read_data", bus, m_e.data);
        chk("bus_drive_in_done", 32'(dut.bus_oe_s), 32'(m_e.rd));
      end
    end else begin
      chk("bus_z_outside_done", 32'(dut.bus_oe_s), 32'd0);
    end
  end

  // Waits (bounded) for the done strobe; returns at the negedge of the done cycle.
  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no done, expected done within 40 cycles", nm);
    end
  endtask

  // One access; the bus value changes to d_after one cycle after accept.
  task automatic access(input logic [3:0] m, input logic [29:0] a, input logic [31:0] d,
                        input logic [31:0] d_after, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    paddr = a; wmask = m; valid = 1'b1; drv = d; oe = (m != 4'b0000);
    sb.push_back('{rd: (m == 4'b0000), data: exp_rd, acc: cyc});
    @(posedge clk); #1;
    drv = d_after;
    wait_done("access");
    @(posedge clk); #1;
    valid = 1'b0; oe = 1'b0;
  endtask

`ifdef MCPU_DCRESP_RANDWAIT_EN
  int lat_a[100];
  int lat_b[100];

  task automatic burst(output int lat[100]);
    int acc;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    paddr = 30'h5; wmask = 4'b0000; valid = 1'b1; oe = 1'b0;
    acc = cyc;
    for (int i = 0; i < 100; i++) begin
      sb.push_back('{rd: 1'b1, data: 32'hCAFEF00D, acc: acc});
      wait_done("burst");
      lat[i] = cyc - acc;
      acc = cyc + 1;
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask
`endif

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    chk("rst_mask", 32'(dut.mask_q), 32'd0);
    chk("rst_rdata", dut.rdata_q, 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Full write, readback, byte-lane write, readback.
    access(4'b1111, 30'h5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    access(4'b0000, 30'h5, 32'h0, 32'h0, 32'hDEADBEEF);
    access(4'b0100, 30'h5, 32'h00AA0000, 32'h00AA0000, 32'h0);
    access(4'b0000, 30'h5, 32'h0, 32'h0, 32'hDEAABEEF);

    // Abort a read during WAIT.
    @(posedge clk); #1;
    paddr = 30'h5; wmask = 4'b0000; valid = 1'b1; oe = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_wait", 32'(dut.state_q), 32'(WAIT));
    valid = 1'b0;
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("abort_idle", 32'(dut.state_q), 32'(IDLE));
    access(4'b0000, 30'h5, 32'h0, 32'h0, 32'hDEAABEEF);

    // Reset asserted in the RESP cycle of a write: no commit.
    @(posedge clk); #1;
    paddr = 30'h5; wmask = 4'b1111; valid = 1'b1; drv = 32'h12345678; oe = 1'b1;
    sb.push_back('{rd: 1'b0, data: 32'h0, acc: cyc});
    k = 0;
    while (dut.state_q != RESP && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reached_resp", 32'(dut.state_q), 32'(RESP));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0; oe = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));
    access(4'b0000, 30'h5, 32'h0, 32'h0, 32'hDEAABEEF);

    // Write data sampled at accept; later bus changes ignored. Lanes 0 and 3.
    access(4'b1111, 30'h7, 32'h00000000, 32'h00000000, 32'h0);
    access(4'b0001, 30'h7, 32'h00000011, 32'h00000077, 32'h0);
    access(4'b0000, 30'h7, 32'h0, 32'h0, 32'h00000011);
    access(4'b1001, 30'h7, 32'hAB0000CD, 32'hFFFFFFFF, 32'h0);
    access(4'b0000, 30'h7, 32'h0, 32'h0, 32'hAB0000CD);

    // Address aliasing above ADDR_BITS.
    access(4'b1111, 30'h405, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0);
    access(4'b0000, 30'h005, 32'h0, 32'h0, 32'hCAFEF00D);

`ifdef MCPU_DCRESP_RANDWAIT_EN
    burst(lat_a);
    burst(lat_b);
    for (int i = 0; i < 100; i++) chk("randwait_repeat", 32'(lat_b[i]), 32'(lat_a[i]));
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcpu_dcache_resp.md
# mcpu_dcache_resp

Data-side memory responder for the core's memory stage: accepts word-addressed requests on the mem2dc_* interface, performs byte-masked writes or full-word reads against an internal SRAM array, and answers with a one-cycle done pulse. It sits on the far side of the mem2dc_* bus, standing in for the data cache until the real cache exists. It also serves as the bench memory model for the core.

## Interface
- ADDR_BITS, 10: word-address bits used to index the array (2^ADDR_BITS words of 32 bits).
- WAIT_CYCLES, 1: fixed wait states between accept and response (0..15).
- clkrst_core_clk  in  1  core clock; all logic on its rising edge.
- clkrst_core_rst  in  1  reset, synchronous, active-high.
- mem2dc_paddr  in  30  word address; bits above ADDR_BITS are ignored (aliasing).
- mem2dc_write  in  4  byte-lane write mask; 0 means read.
- mem2dc_valid  in  1  request valid, held by the initiator until done.
- mem2dc_done  out  1  one-cycle response strobe.
- mem2dc_data  inout  32  write data in from the initiator; read data out from this block; Z otherwise.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if mem2dc_valid, latch address, mask and (if mask≠0) mem2dc_data, then load wait counter with WAIT_CYCLES. Go to WAIT if the count is >0, else go to RESP.
- WAIT: decrement the counter. On its last cycle (counter==1), read the array into rdata_q, then go to RESP.
- WAIT_CYCLES=0: the array read happens on the accept cycle.
- RESP: assert done. For a write, commit the latched data to the array on byte lanes where mask[i]=1 (lane i = bits 8i+7:8i). For a read, drive rdata_q onto mem2dc_data. Next state is IDLE.
- Abort: if mem2dc_valid is low in WAIT or RESP, go to IDLE immediately. No done, no array write, bus stays Z.
- Bus drive: mem2dc_data = rdata_q only when state==RESP and mask==0 and mem2dc_valid; otherwise 32'bZ. This block never drives during write requests.
- Valid still high in IDLE after a RESP is a new request (the initiator presents the next access or drops valid).
- Reset values: state IDLE, mem2dc_done 0, bus Z, counter 0, latched mask 0, rdata_q 0. Array contents are not reset.
- Reset mid-transaction: abandon it; no array write, even if asserted in RESP.

## Timing
- mem2dc_done and the bus enable decode from registered state only; there is no combinational path from inputs except the valid gating.
- Latency: request accepted in cycle N; done in cycle N+1+WAIT_CYCLES (WAIT_CYCLES=0 gives N+1).
- Throughput: one access per 2+WAIT_CYCLES cycles.
- Write data is sampled at accept. Changes on the bus afterwards are ignored.
- Read data is valid on the bus exactly in the done cycle.

## Configuration
- MCPU_DCRESP_RANDWAIT_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) steps every cycle and is seeded 16'hACE1 on reset. At accept, lfsr[1:0] (0..3) is added to WAIT_CYCLES, which stresses the initiator's handshake deterministically.
- MCPU_DCRESP_RANDWAIT_EN undefined: no LFSR, latency fixed at 1+WAIT_CYCLES.

## Structure
- Package mcpu_dcresp_pkg holds:
  - the state enum (IDLE/WAIT/RESP)
  - the LFSR seed and tap constants
  - word/mask width constants (32, 4, 30).
- Sub-module mcpu_lfsr16: the LFSR, instantiated only under MCPU_DCRESP_RANDWAIT_EN.
- The array is inferred inline as a per-byte-lane write-enabled register memory.

## Test plan
- Full-word write then read (WAIT_CYCLES=1): write 0xDEADBEEF, mask 4'b1111, paddr 0x5, accepted cycle N -> done at N+2. Then read paddr 0x5 -> bus 0xDEADBEEF in the done cycle, Z before and after.
- Byte write: write 0x00AA0000, mask 4'b0100, paddr 0x5 -> subsequent read returns 0xDEAABEEF.
- Abort: read paddr 0x5, drop valid during WAIT -> no done, bus stays Z, state IDLE next cycle. A following read still returns 0xDEAABEEF.
- Reset in RESP: write 0x12345678, mask 4'b1111, paddr 0x5, assert clkrst_core_rst in the RESP cycle -> done 0 after reset, and a read returns 0xDEAABEEF.
- Aliasing (ADDR_BITS=10): write 0xCAFEF00D to paddr 0x405 -> read paddr 0x005 returns 0xCAFEF00D.
- Random waits, built with MCPU_DCRESP_RANDWAIT_EN and WAIT_CYCLES=1: 100 back-to-back reads -> every latency in 2..5, latency sequence identical across two runs from reset.
